// File: rtl/control_rsp_sendbrightness_pkg.sv
// Shared types and default frame constants for the brightness response path.
package types;

    typedef logic [7:0] brightness_level_t;

    localparam logic [7:0] RSP_HDR_BRIGHTNESS = 8'h62;
    localparam logic [7:0] RSP_TERMINATOR     = 8'h0A;

endpackage

// File: rtl/control_rsp_sendbrightness.sv
// Sends a 4-byte brightness response frame (header, value, checksum, terminator)
// over a valid/ready byte interface, with a per-byte stall timeout.
module control_rsp_sendbrightness #(
    parameter logic [7:0]  RSP_HEADER     = types::RSP_HDR_BRIGHTNESS,
    parameter logic [7:0]  RSP_TERMINATOR = types::RSP_TERMINATOR,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  types::brightness_level_t brightness_in,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_VAL,
        SEND_CHK,
        SEND_EOL,
        FINISH
    } state_t;

    state_t                   state_q, state_d;
    types::brightness_level_t snap_q, snap_d;
    logic [CNT_W-1:0]         stall_q, stall_d;
    logic                     gap_q, gap_d;
    logic                     terr_q, terr_d;

    state_t                   after_xfer;
    logic [7:0]               cur_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            stall_q <= '0;
            gap_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        stall_d    = stall_q;
        gap_d      = 1'b0;
        terr_d     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        after_xfer = IDLE;
        cur_byte   = '0;

        case (state_q)
            SEND_HDR: begin
                cur_byte   = RSP_HEADER;
                after_xfer = SEND_VAL;
            end
            SEND_VAL: begin
                cur_byte   = snap_q;
                after_xfer = SEND_CHK;
            end
            SEND_CHK: begin
                cur_byte   = RSP_HEADER ^ snap_q;
                after_xfer = SEND_EOL;
            end
            SEND_EOL: begin
                cur_byte   = RSP_TERMINATOR;
                after_xfer = FINISH;
            end
            default: begin
                cur_byte   = '0;
                after_xfer = IDLE;
            end
        endcase

        case (state_q)
            IDLE: begin
                if (enable) begin
                    snap_d  = brightness_in;
                    stall_d = '0;
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR, SEND_VAL, SEND_CHK, SEND_EOL: begin
                busy     = 1'b1;
                // gap_q marks the mandatory idle cycle following each transfer
                tx_valid = !gap_q;
                tx_data  = gap_q ? 8'h00 : cur_byte;
                if (tx_valid && tx_ready) begin
                    state_d = after_xfer;
                    stall_d = '0;
                    gap_d   = 1'b1;
                end else if (tx_valid) begin
                    stall_d = stall_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (stall_d == STALL_LIMIT)) begin
                        state_d = IDLE;
                        stall_d = '0;
                        terr_d  = 1'b1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timeout_err = terr_q;

endmodule

// File: tb/tb_control_rsp_sendbrightness.sv
// Bench for control_rsp_sendbrightness: directed table, randomized frames and
// reset-in-frame sequence, checked against a frame-level reference model.
module tb_control_rsp_sendbrightness;

    localparam logic [7:0] HDR = 8'h62;
    localparam logic [7:0] EOL = 8'h0A;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      en, rdy, txv, busy, done, terr;
    logic [1:0][7:0] br, txd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_rsp_sendbrightness dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .brightness_in(br[0]),
        .tx_ready(rdy[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
        .busy(busy[0]), .done(done[0]), .timeout_err(terr[0])
    );

    control_rsp_sendbrightness #(.TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .brightness_in(br[1]),
        .tx_ready(rdy[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
        .busy(busy[1]), .done(done[1]), .timeout_err(terr[1])
    );

    typedef struct {
        int         d;
        logic [7:0] b;
        logic [7:0] ba;
        int         s;
        int         sf;
        int         re;
        logic [31:0] fr;
        int         nb;
        int         dc;
        int         tc;
        int         ns;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Frame content from the protocol rule: byte i sits at bits [8*i +: 8]
    function automatic logic [31:0] model_frame(input logic [7:0] b);
        return {EOL, HDR ^ b, b, HDR};
    endfunction

    task automatic run_frame(input int d, input logic [7:0] b, input logic [7:0] b_after,
                             input int stall, input int stall_from, input int reen,
                             output logic [31:0] got, output int nbytes, output int ndone,
                             output int done_cyc, output int nto, output int to_cyc,
                             output int nstall, output int nviol);
        int         st;
        logic       prev_stalled;
        logic       prev_xfer;
        logic [7:0] prev_data;
        got = '0; nbytes = 0; ndone = 0; done_cyc = -1; nto = 0; to_cyc = -1;
        nstall = 0; nviol = 0; st = 0;
        prev_stalled = 1'b0; prev_xfer = 1'b0; prev_data = '0;
        br[d] = b; en[d] = 1'b1; rdy[d] = 1'b0;
        step();
        en[d] = 1'b0; br[d] = b_after;
        for (int c = 1; c < 300; c++) begin
            en[d] = (c == reen);
            if (!txv[d] && txd[d] != 8'h00) nviol++;
            if (prev_xfer && txv[d]) nviol++;
            if (prev_stalled && !terr[d] && (!txv[d] || txd[d] != prev_data)) nviol++;
            if (busy[d] !== !(done[d] || terr[d])) nviol++;
            prev_stalled = 1'b0;
            prev_xfer = 1'b0;
            if (done[d]) begin ndone++; done_cyc = c; end
            if (terr[d]) begin nto++; to_cyc = c; end
            if (txv[d]) begin
                if (st < ((nbytes >= stall_from) ? stall : 0)) begin
                    rdy[d] = 1'b0; st++; nstall++;
                    prev_stalled = 1'b1; prev_data = txd[d];
                end else begin
                    rdy[d] = 1'b1;
                    if (nbytes < 4) got[8*nbytes +: 8] = txd[d];
                    nbytes++; st = 0; prev_xfer = 1'b1;
                end
            end else begin
                rdy[d] = 1'($urandom_range(0, 1));
            end
            if (done[d] || terr[d]) break;
            step();
        end
        step();
        en[d] = 1'b0;
        if (busy[d] || txv[d] || done[d] || terr[d]) nviol++;
    endtask

    task automatic frame_check(input string tag, input int d, input logic [7:0] b,
                               input logic [7:0] b_after, input int stall, input int stall_from,
                               input int reen, input logic [31:0] exp_frame, input int exp_bytes,
                               input int exp_done_cyc, input int exp_to_cyc, input int exp_stall);
        logic [31:0] got;
        int nbytes, ndone, done_cyc, nto, to_cyc, nstall, nviol;
        run_frame(d, b, b_after, stall, stall_from, reen,
                  got, nbytes, ndone, done_cyc, nto, to_cyc, nstall, nviol);
        check($sformatf("%s.nbytes", tag), nbytes, exp_bytes);
        for (int k = 0; k < 4; k++)
            if (k < exp_bytes)
                check($sformatf("%s.byte%0d", tag, k), int'(got[8*k +: 8]), int'(exp_frame[8*k +: 8]));
        check($sformatf("%s.ndone", tag), ndone, (exp_done_cyc >= 0) ? 1 : 0);
        check($sformatf("%s.done_cyc", tag), done_cyc, exp_done_cyc);
        check($sformatf("%s.nto", tag), nto, (exp_to_cyc >= 0) ? 1 : 0);
        check($sformatf("%s.to_cyc", tag), to_cyc, exp_to_cyc);
        check($sformatf("%s.nstall", tag), nstall, exp_stall);
        check($sformatf("%s.protocol", tag), nviol, 0);
    endtask

    initial begin
        vec_t tbl [8];
        int   nv;
        tbl[0] = '{0, 8'h80, 8'h80, 0,   0, -1, {EOL, 8'hE2, 8'h80, HDR}, 4, 8,  -1, 0};
        tbl[1] = '{0, 8'h00, 8'h00, 5,   0, -1, {EOL, 8'h62, 8'h00, HDR}, 4, 28, -1, 20};
        tbl[2] = '{0, 8'h10, 8'hFF, 0,   0, -1, {EOL, 8'h72, 8'h10, HDR}, 4, 8,  -1, 0};
        tbl[3] = '{0, 8'h5A, 8'h5A, 0,   0, 3,  {EOL, 8'h38, 8'h5A, HDR}, 4, 8,  -1, 0};
        tbl[4] = '{1, 8'h33, 8'h33, 100, 1, -1, {EOL, 8'h51, 8'h33, HDR}, 1, -1, 7,  4};
        tbl[5] = '{1, 8'hC3, 8'hC3, 0,   0, -1, {EOL, 8'hA1, 8'hC3, HDR}, 4, 8,  -1, 0};
        tbl[6] = '{1, 8'hA5, 8'hA5, 3,   0, -1, {EOL, 8'hC7, 8'hA5, HDR}, 4, 20, -1, 12};
        tbl[7] = '{0, 8'hFF, 8'h00, 1,   0, 12, {EOL, 8'h9D, 8'hFF, HDR}, 4, 12, -1, 4};

        reset = 1'b0; en = '0; rdy = '0; br = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.dut0", int'({txv[0], busy[0], done[0], terr[0], txd[0]}), 0);
        check("reset.dut1", int'({txv[1], busy[1], done[1], terr[1], txd[1]}), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++)
            frame_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].b, tbl[i].ba, tbl[i].s,
                        tbl[i].sf, tbl[i].re, tbl[i].fr, tbl[i].nb, tbl[i].dc, tbl[i].tc, tbl[i].ns);

        for (int i = 0; i < 20; i++) begin
            int         d;
            int         s;
            int         re;
            logic [7:0] b;
            logic [7:0] ba;
            d  = int'($urandom_range(0, 1));
            s  = int'($urandom_range(0, 3));
            b  = 8'($urandom());
            ba = 8'($urandom());
            re = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8 + 4 * s)) : -1;
            frame_check($sformatf("rnd%0d", i), d, b, ba, s, 0, re,
                        model_frame(b), 4, 8 + 4 * s, -1, 4 * s);
        end

        // Reset while the checksum byte is on the bus
        br[0] = 8'h44; en[0] = 1'b1; rdy[0] = 1'b1;
        step();
        en[0] = 1'b0;
        repeat (4) step();
        check("rst.pre_valid", int'(txv[0]), 1);
        check("rst.pre_chk", int'(txd[0]), 8'h26);
        reset = 1'b0;
        #1;
        check("rst.async", int'({txv[0], busy[0], done[0], terr[0], txd[0]}), 0);
        nv = 0;
        repeat (3) begin
            step();
            if (txv[0] || done[0] || terr[0] || busy[0]) nv++;
        end
        check("rst.quiet", nv, 0);
        reset = 1'b1;
        frame_check("rst.fresh", 0, 8'h99, 8'h99, 0, 0, -1,
                    {EOL, 8'hFB, 8'h99, HDR}, 4, 8, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_rsp_sendbrightness.md
CONTROL_RSP_SENDBRIGHTNESS -- requirements
Module: control_rsp_sendbrightness

Interface
REQ-001 SHALL have parameter RSP_HEADER, default 8'h62, first byte of every brightness response frame.
REQ-002 SHALL have parameter RSP_TERMINATOR, default 8'h0A, last byte of every frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum consecutive stalled cycles per byte; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  one-cycle request to send the current brightness.
REQ-007 SHALL have port brightness_in  input  types::brightness_level_t (8)  live brightness value.
REQ-008 SHALL have port tx_ready  input  1  downstream byte transmitter can accept a byte.
REQ-009 SHALL have port tx_data  output  8  byte offered downstream.
REQ-010 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on successful frame completion.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on frame abort.

Function
REQ-014 SHALL implement states IDLE, SEND_HDR, SEND_VAL, SEND_CHK, SEND_EOL and FINISH.
REQ-015 SHALL, in IDLE with enable=1, capture brightness_in into a snapshot register, set busy=1 and enter SEND_HDR on the next cycle.
REQ-016 SHALL ignore enable in every state except IDLE; no queuing.
REQ-017 SHALL emit the frame as RSP_HEADER, snapshot, checksum, RSP_TERMINATOR, where checksum = RSP_HEADER XOR snapshot (8-bit).
REQ-018 SHALL assert tx_valid in each SEND_* state, with tx_data stable until transfer.
REQ-019 SHALL treat a rising edge with tx_valid=1 and tx_ready=1 as a transfer, and advance to the next state on that edge.
REQ-020 SHALL deassert tx_valid for exactly one cycle between consecutive bytes.
REQ-021 SHALL enter FINISH after the SEND_EOL transfer, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-022 SHALL make the earliest next accepted enable the cycle after FINISH.
REQ-023 SHALL, with zero backpressure, take 1 capture cycle, 4 byte cycles plus 3 gap cycles, and 1 FINISH cycle: 9 cycles from enable to done.
REQ-024 SHALL use a stall counter of width $clog2(TIMEOUT_CYCLES+1) that clears on every transfer and on state entry, and increments each cycle tx_valid=1 and tx_ready=0.
REQ-025 SHALL, when the stall counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES is not 0), drop tx_valid, pulse timeout_err for one cycle, not pulse done, clear busy and return to IDLE.
REQ-026 SHALL give a transfer priority over a timeout reached on the same edge.
REQ-027 SHALL send the snapshot value, unaffected by brightness_in changes during a frame.
REQ-028 SHALL drive tx_data=8'h00 whenever tx_valid=0.

Reset
REQ-029 SHALL, when reset=0, asynchronously force state=IDLE, tx_data=0, tx_valid=0, busy=0, done=0, timeout_err=0, snapshot=0 and stall counter=0.
REQ-030 SHALL, on reset mid-frame, abandon the frame with no done or timeout_err pulse, and emit no further bytes.
REQ-031 SHALL accept enable on the first rising edge after reset deasserts.

Structure
REQ-032 SHALL take brightness_level_t and the default header/terminator constants (RSP_HDR_BRIGHTNESS, RSP_TERMINATOR) from package types.
REQ-033 SHALL keep the state enum local to the module.
REQ-034 SHALL contain no sub-module; the checksum is a single XOR.

Verification
REQ-035 SHALL cover: brightness_in=8'h80, enable pulse, tx_ready=1 -> bytes 62,80,E2,0A; done exactly 9 cycles after enable.
REQ-036 SHALL cover: brightness_in=8'h00, tx_ready low 5 cycles per byte -> bytes 62,00,62,0A, tx_data stable while stalled, single done.
REQ-037 SHALL cover: brightness_in changed from 8'h10 to 8'hFF after capture -> value byte 10, checksum 72.
REQ-038 SHALL cover: TIMEOUT_CYCLES=4, tx_ready=0 after header -> timeout_err after 4 stalled cycles, no done, busy=0, next enable accepted.
REQ-039 SHALL cover: second enable during SEND_VAL -> ignored, exactly one frame sent.
REQ-040 SHALL cover: reset asserted during SEND_CHK -> all outputs 0 immediately, no done, fresh frame correct after release.
